// File: rtl/ir_pkg.sv
// Shared constants for the instruction queue: default widths, NOP encoding
// and the opcode values carried in the top OP_W bits of an instruction.
package ir_pkg;

   localparam int IR_N    = 16;
   localparam int IR_OP_W = 4;

   // Instruction word loaded into the holding register after reset.
   localparam logic [IR_N-1:0] IR_NOP = 16'h0000;

   typedef enum logic [IR_OP_W-1:0] {
      OP_NOP   = 4'h0,
      OP_LOAD  = 4'h1,
      OP_STORE = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_HALT  = 4'hF
   } opcode_e;

endpackage : ir_pkg

// File: rtl/ir_fifo_mem.sv
// DEPTH x N instruction storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module ir_fifo_mem #(
   parameter int N     = 16,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [N-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [N-1:0]  o_rdata
);

   logic [N-1:0] r_mem [DEPTH];

   // Store the fetched word at the write pointer when a push is accepted.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : ir_fifo_mem

// File: rtl/instruction_queue.sv
// Instruction FIFO feeding a holding instruction register. Fetch pushes
// words, the control unit pops them into q with ir_ld, and a branch flush
// discards everything queued while leaving q untouched.
module instruction_queue
   import ir_pkg::*;
#(
   parameter int            N         = IR_N,
   parameter int            DEPTH     = 4,
   parameter int            OP_W      = IR_OP_W,
   parameter logic [N-1:0]  RESET_VAL = IR_NOP
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N-1:0]             i_d,
   input  logic                     i_d_valid,
   output logic                     o_d_ready,
   input  logic                     i_ir_ld,
   input  logic                     i_flush,
   output logic [N-1:0]             o_q,
   output logic [OP_W-1:0]          o_opcode,
   output logic                     o_q_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_empty;
   logic          r_full;
   logic [N-1:0]  r_q;
   logic          r_q_valid;
   logic          r_underflow;

   logic          w_push;
   logic          w_pop;
   logic          w_uflow;
   logic [CW-1:0] w_count_nxt;
   logic [N-1:0]  w_head;

   // Flush overrides both sides; push is gated by full, pop by empty, so a
   // full queue with push+pop only pops and an empty one only pushes.
   assign w_push  = i_d_valid && !r_full  && !i_flush;
   assign w_pop   = i_ir_ld   && !r_empty && !i_flush;
   assign w_uflow = i_ir_ld   &&  r_empty && !i_flush;

   ir_fifo_mem #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_d),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      w_count_nxt = r_count;
      if (i_flush) begin
         w_count_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Pointers, occupancy flags, instruction register and sticky underflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_q         <= RESET_VAL;
         r_q_valid   <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == DEPTH_C);
         if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_valid <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr  <= r_rd_ptr + AW'(1);
               r_q       <= w_head;
               r_q_valid <= 1'b1;
            end
            if (w_uflow) begin
               r_underflow <= 1'b1;
            end
         end
      end
   end

   assign o_d_ready   = !r_full;
   assign o_q         = r_q;
   assign o_opcode    = r_q[N-1:N-OP_W];
   assign o_q_valid   = r_q_valid;
   assign o_count     = r_count;
   assign o_empty     = r_empty;
   assign o_full      = r_full;
   assign o_underflow = r_underflow;

endmodule : instruction_queue
